// File: rtl/serial_add_pkg.sv
// Shared types and constants for the chunk-serial adder controller.
// One 3-bit slice is reused every cycle, so CHUNK fixes the operand step.
package serial_add_pkg;

    localparam int CHUNK = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add_state_t;

endpackage

// File: rtl/add_slice3.sv
// Combinational 3-bit ripple-carry adder slice built from per-bit full adders.
module add_slice3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       c_in,
    output logic [2:0] sum,
    output logic       c_out
);

    logic [3:0] carry;

    // Ripple the carry through three full adders, LSB first.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < 3; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = carry[3];

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder that reuses one 3-bit slice, one chunk per clock, LSB chunk first.
// The carry is held in a flop between chunks; result and carry-out are registered.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

    generate
        if (WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH must be a positive multiple of 3");
        end
    endgenerate

    add_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [2:0]       sliceSum;
    logic             sliceCout;
    logic [WIDTH-1:0] sumShift;

    add_slice3 u_slice (
        .a     (a_q[2:0]),
        .b     (b_q[2:0]),
        .c_in  (carry_q),
        .sum   (sliceSum),
        .c_out (sliceCout)
    );

    // New chunks enter at the top so the LSB chunk ends up at bit 0 after NCHUNK shifts.
    generate
        if (WIDTH == CHUNK) begin : g_single
            assign sumShift = sliceSum;
        end else begin : g_multi
            assign sumShift = {sliceSum, sum_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = sumShift;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = sliceCout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = sliceCout;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule
